lvds_rx_word_align: RTL and testbench

LVDS_RX_WORD_ALIGN -- requirements
Module: lvds_rx_word_align

---
 rtl/lvds_rx_word_align.sv | 144 ++++++++++++++
 tb/tb_lvds_rx_word_align.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lvds_rx_word_align.sv
// Word aligner for an LVDS deserializer: slips until TRAIN_PATTERN is seen MATCH_COUNT times in a row.
// Define LVDS_RX_ALIGN_AUTO_RETRY_EN to leave FAIL on its own after 256 cycles.
module lvds_rx_word_align #(
  parameter int               WIDTH         = 6,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = 6'b111000,
  parameter int               MATCH_COUNT   = 16,
  parameter int               SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             align_start,
  output logic             bitslip,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             aligned,
  output logic             align_fail
);
  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int SW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, CHECK, SLIP, SETTLE, ALIGNED, FAIL} state_t;

  state_t           state_q, state_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic [SW-1:0]    slip_cnt_q, slip_cnt_d;
  logic [TW-1:0]    settle_cnt_q, settle_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             sync1_q, sync2_q;
  logic             locked_s;
`ifdef LVDS_RX_ALIGN_AUTO_RETRY_EN
  logic [7:0]       retry_cnt_q, retry_cnt_d;
`endif

  assign locked_s = sync2_q;

  always_comb begin
    state_d      = state_q;
    match_cnt_d  = match_cnt_q;
    slip_cnt_d   = slip_cnt_q;
    settle_cnt_d = settle_cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
`ifdef LVDS_RX_ALIGN_AUTO_RETRY_EN
    retry_cnt_d  = '0;
`endif
    if (!locked_s) begin
      // Losing lock overrides everything, including a same-cycle align_start.
      state_d      = IDLE;
      match_cnt_d  = '0;
      slip_cnt_d   = '0;
      settle_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (align_start) begin
          state_d     = CHECK;
          match_cnt_d = '0;
          slip_cnt_d  = '0;
        end
        CHECK: if (rx_data == TRAIN_PATTERN) begin
          match_cnt_d = match_cnt_q + 1'b1;
          if (match_cnt_d == MW'(MATCH_COUNT)) state_d = ALIGNED;
        end else begin
          match_cnt_d = '0;
          state_d     = (slip_cnt_q < SW'(WIDTH)) ? SLIP : FAIL;
        end
        SLIP: begin
          slip_cnt_d   = slip_cnt_q + 1'b1;
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end
        SETTLE: if (settle_cnt_q == TW'(SETTLE_CYCLES - 1)) begin
          settle_cnt_d = '0;
          match_cnt_d  = '0;
          state_d      = CHECK;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
        ALIGNED: if (align_start) begin
          state_d     = CHECK;
          match_cnt_d = '0;
          slip_cnt_d  = '0;
        end
        FAIL: if (align_start) begin
          state_d     = CHECK;
          match_cnt_d = '0;
          slip_cnt_d  = '0;
        end else begin
`ifdef LVDS_RX_ALIGN_AUTO_RETRY_EN
          retry_cnt_d = retry_cnt_q + 1'b1;
          if (retry_cnt_q == 8'hff) begin
            state_d     = CHECK;
            match_cnt_d = '0;
            slip_cnt_d  = '0;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
    // Keyed on the next state so data_valid and aligned rise and fall together.
    if (state_d == ALIGNED) begin
      data_valid_d = 1'b1;
      data_out_d   = rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      match_cnt_q  <= '0;
      slip_cnt_q   <= '0;
      settle_cnt_q <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
`ifdef LVDS_RX_ALIGN_AUTO_RETRY_EN
      retry_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      match_cnt_q  <= match_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      sync1_q      <= pll_locked;
      sync2_q      <= sync1_q;
`ifdef LVDS_RX_ALIGN_AUTO_RETRY_EN
      retry_cnt_q  <= retry_cnt_d;
`endif
    end
  end

  assign bitslip    = (state_q == SLIP);
  assign aligned    = (state_q == ALIGNED);
  assign align_fail = (state_q == FAIL);
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
endmodule

// File: tb/tb_lvds_rx_word_align.sv
// Directed bench for lvds_rx_word_align with a rotating-deserializer model on rx_data.
module tb_lvds_rx_word_align;
  localparam logic [5:0] PAT = 6'b111000;

  logic       clk = 1'b0;
  logic       rst, pll_locked, align_start;
  logic [5:0] rx_data;
  logic       bitslip, data_valid, aligned, align_fail;
  logic [5:0] data_out;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, nslip = 0, last_slip = -1000, min_gap = 1000;
  int mode = 0, start_off = 0, slip_off = 0;
  logic [5:0] free_data = '0;

  typedef struct { int off; int md; int slips; int cyc; int al; int fl; } vec_t;
  vec_t vecs[5];

  lvds_rx_word_align dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .rx_data(rx_data),
    .align_start(align_start), .bitslip(bitslip), .data_out(data_out),
    .data_valid(data_valid), .aligned(aligned), .align_fail(align_fail)
  );

  always #4 clk = ~clk;

  function automatic logic [5:0] rot(input int k);
    logic [11:0] t;
    t = {PAT, PAT} << k;
    return t[11:6];
  endfunction

  // Deserializer model: mode 0 rotated training stream, 1 all zeros, 2 free data.
  always_comb begin
    rx_data = rot((start_off + slip_off) % 6);
    if (mode == 1) rx_data = '0;
    else if (mode == 2) rx_data = free_data;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (bitslip) begin
      nslip++;
      if (cyc - last_slip < min_gap) min_gap = cyc - last_slip;
      last_slip = cyc;
      slip_off++;
    end
  endtask

  task automatic clr_model();
    nslip = 0; slip_off = 0; last_slip = -1000; min_gap = 1000;
  endtask

  task automatic align_run(input int off, input int md, output int got);
    mode = md; start_off = off; clr_model();
    got = 0;
    align_start = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      step();
      align_start = 1'b0;
      if (aligned || align_fail) begin got = c; break; end
    end
  endtask

  initial begin
    int got, left;
    logic [5:0] v, last_v;
    vecs[0] = '{0, 0, 0, 17, 1, 0};
    vecs[1] = '{3, 0, 3, 35, 1, 0};
    vecs[2] = '{1, 0, 5, 47, 1, 0};
    vecs[3] = '{5, 0, 1, 23, 1, 0};
    vecs[4] = '{0, 1, 6, 38, 0, 1};

    rst = 1'b1; pll_locked = 1'b1; align_start = 1'b0;
    step(); step();
    chk("rst_bitslip", bitslip, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_aligned", aligned, 0);
    chk("rst_align_fail", align_fail, 0);
    rst = 1'b0;
    repeat (3) step();

    for (int i = 0; i < 5; i++) begin
      align_run(vecs[i].off, vecs[i].md, got);
      chk($sformatf("v%0d_cycles", i), got, vecs[i].cyc);
      chk($sformatf("v%0d_slips", i), nslip, vecs[i].slips);
      chk($sformatf("v%0d_aligned", i), aligned, vecs[i].al);
      chk($sformatf("v%0d_fail", i), align_fail, vecs[i].fl);
      if (vecs[i].slips >= 2) chk($sformatf("v%0d_gap_ok", i), int'(min_gap >= 5), 1);
    end

    // FAIL persistence (or automatic retry when that option is built in)
    clr_model();
`ifdef LVDS_RX_ALIGN_AUTO_RETRY_EN
    left = 0;
    for (int c = 1; c <= 300; c++) begin
      step();
      if (!align_fail) begin left = c; break; end
    end
    chk("auto_retry_left_fail", int'(left > 0), 1);
    for (int c = 0; c < 100 && !align_fail; c++) step();
`else
    left = 0;
    repeat (300) step();
    chk("fail_sticky", align_fail, 1);
    chk("fail_no_slip", nslip, 0);
`endif

    align_run(0, 0, got);
    chk("realign_from_fail", got, 17);

    // data_out follows rx_data with one cycle latency while aligned
    mode = 2;
    for (int i = 0; i < 8; i++) begin
      v = 6'($urandom_range(0, 63));
      free_data = v;
      step();
      chk($sformatf("dout_lat%0d", i), data_out, v);
      chk($sformatf("dvalid%0d", i), data_valid, 1);
      last_v = v;
    end

    // re-alignment request drops data_valid and freezes data_out
    mode = 1; align_start = 1'b1;
    step();
    align_start = 1'b0;
    chk("realign_dvalid", data_valid, 0);
    chk("realign_aligned", aligned, 0);
    repeat (3) step();
    chk("dout_held", data_out, last_v);
    for (int c = 0; c < 100 && !align_fail; c++) step();
    chk("realign_zeros_fail", align_fail, 1);

    // lock lost while aligned
    align_run(0, 0, got);
    chk("align_before_lockdrop", got, 17);
    pll_locked = 1'b0;
    repeat (3) step();
    chk("lockdrop_aligned", aligned, 0);
    chk("lockdrop_dvalid", data_valid, 0);
    align_start = 1'b1;
    step();
    align_start = 1'b0;
    pll_locked = 1'b1;
    mode = 0; start_off = 0; clr_model();
    repeat (25) step();
    chk("start_unlocked_ignored", aligned, 0);
    chk("start_unlocked_noslip", nslip, 0);

    // reset while bitslip is high
    mode = 1; clr_model();
    align_start = 1'b1;
    got = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      align_start = 1'b0;
      if (bitslip) begin got = c; break; end
    end
    chk("slip_seen_before_rst", int'(got > 0), 1);
    rst = 1'b1;
    step();
    chk("rst_midslip_bitslip", bitslip, 0);
    chk("rst_midslip_dout", data_out, 0);
    chk("rst_midslip_dvalid", data_valid, 0);
    chk("rst_midslip_aligned", aligned, 0);
    chk("rst_midslip_fail", align_fail, 0);
    rst = 1'b0;
    clr_model();
    repeat (20) step();
    chk("after_rst_idle_noslip", nslip, 0);

    // align_start in the cycle the synchronized lock goes low
    align_run(0, 0, got);
    chk("align_before_race", got, 17);
    pll_locked = 1'b0;
    step(); step();
    align_start = 1'b1;
    step();
    align_start = 1'b0;
    chk("race_aligned", aligned, 0);
    chk("race_dvalid", data_valid, 0);
    pll_locked = 1'b1;
    mode = 0; start_off = 0; clr_model();
    repeat (25) step();
    chk("race_idle", aligned, 0);
    chk("race_noslip", nslip, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
